// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline package for the hazard scoreboard: register index width,
// default sizing constants and the issue-control FSM state encoding.
package hazard_scoreboard_pkg;

  localparam int REG_W      = 5;
  localparam int NREG_DEF   = 32;
  localparam int CNT_W_DEF  = 2;
  localparam int PERF_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } sb_state_e;

endpackage

// File: rtl/hazard_scoreboard_sb_counter_bank.sv
// sb_counter_bank: one pending-write counter per architectural register.
// Register 0 is hard-wired to zero. A simultaneous increment and decrement
// of the same register cancel out. A decrement of a zero counter leaves it
// at zero and is reported on o_dec_err (writes to register 0 are ignored).
module sb_counter_bank
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_inc_en,
  input  logic [REG_W-1:0]            i_inc_idx,
  input  logic                        i_dec_en,
  input  logic [REG_W-1:0]            i_dec_idx,
  output logic [NREG-1:0][CNT_W-1:0]  o_pend,
  output logic                        o_all_zero,
  output logic                        o_dec_err
);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_cnt
      logic             w_inc;
      logic             w_dec;
      logic [CNT_W-1:0] r_cnt;

      assign w_inc = i_inc_en && (i_inc_idx == REG_W'(gi));
      assign w_dec = i_dec_en && (i_dec_idx == REG_W'(gi));

      // Per-register counter; register 0 is never tracked
      always_ff @(posedge clk) begin
        if (rst || (gi == 0)) begin
          r_cnt <= '0;
        end else if (w_inc && !w_dec) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end else if (w_dec && !w_inc && (r_cnt != '0)) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end

      assign o_pend[gi] = r_cnt;
    end
  endgenerate

  assign o_all_zero = (o_pend == '0);
  assign o_dec_err  = i_dec_en && (i_dec_idx != '0) && (o_pend[i_dec_idx] == '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-order issue scoreboard with per-register pending
// write counters, a RUN/DRAIN/HALTED issue FSM, a saturating stall counter
// and a sticky writeback-underflow error flag.
// Optional feature macro: HAZARD_WB_BYPASS_EN -- a source operand whose only
// pending write retires this very cycle is not treated as a hazard
// (write-through register file).
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PERF_W = PERF_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_rt_used,
  input  logic              id_wb,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              wb_en,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic              halt_req,
  output logic              issue,
  output logic              stall,
  output logic              halted,
  output logic [PERF_W-1:0] stall_cnt,
  output logic              sb_err
);

  sb_state_e               r_state;
  logic [PERF_W-1:0]       r_stall_cnt;
  logic                    r_sb_err;

  logic [NREG-1:0][CNT_W-1:0] w_pend;
  logic                    w_all_zero;
  logic                    w_dec_err;
  logic [CNT_W-1:0]        w_pend_rs;
  logic [CNT_W-1:0]        w_pend_rt;
  logic [CNT_W-1:0]        w_pend_rd;
  logic                    w_rs_byp;
  logic                    w_rt_byp;
  logic                    w_rs_haz;
  logic                    w_rt_haz;
  logic                    w_rd_full;
  logic                    w_hazard;
  logic                    w_issue;
  logic                    w_inc_en;

  sb_counter_bank #(
    .NREG  (NREG),
    .CNT_W (CNT_W)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .i_inc_en   (w_inc_en),
    .i_inc_idx  (id_rd),
    .i_dec_en   (wb_en),
    .i_dec_idx  (wb_rd),
    .o_pend     (w_pend),
    .o_all_zero (w_all_zero),
    .o_dec_err  (w_dec_err)
  );

  assign w_pend_rs = w_pend[id_rs];
  assign w_pend_rt = w_pend[id_rt];
  assign w_pend_rd = w_pend[id_rd];

`ifdef HAZARD_WB_BYPASS_EN
  // The last outstanding write lands this cycle and is visible to the read
  assign w_rs_byp = wb_en && (wb_rd == id_rs) && (w_pend_rs == CNT_W'(1));
  assign w_rt_byp = wb_en && (wb_rd == id_rt) && (w_pend_rt == CNT_W'(1));
`else
  assign w_rs_byp = 1'b0;
  assign w_rt_byp = 1'b0;
`endif

  assign w_rs_haz  = (id_rs != '0) && (w_pend_rs != '0) && !w_rs_byp;
  assign w_rt_haz  = id_rt_used && (id_rt != '0) && (w_pend_rt != '0) && !w_rt_byp;
  // A full destination counter cannot accept another in-flight write
  assign w_rd_full = id_wb && (id_rd != '0) && (w_pend_rd == '1);
  assign w_hazard  = w_rs_haz || w_rt_haz || w_rd_full;

  // A halt request blocks issue even for a hazard-free instruction
  assign w_issue  = !rst && id_valid && (r_state == ST_RUN) && !halt_req && !w_hazard;
  assign w_inc_en = w_issue && id_wb && (id_rd != '0);

  assign issue     = w_issue;
  assign stall     = !rst && id_valid && !w_issue;
  assign halted    = !rst && (r_state == ST_HALTED);
  assign stall_cnt = r_stall_cnt;
  assign sb_err    = r_sb_err;

  // Issue-control FSM: stop issuing on halt, wait for writes to drain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (halt_req) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!halt_req)       r_state <= ST_RUN;
          else if (w_all_zero) r_state <= ST_HALTED;
        end
        ST_HALTED: begin
          if (!halt_req) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Saturating stall-cycle counter and sticky writeback-underflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_sb_err    <= 1'b0;
    end else begin
      if (stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      if (w_dec_err) r_sb_err <= 1'b1;
    end
  end

endmodule
